serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor that computes diff = a - b, LSB first, one bit per clock.
- Built around the half/full-subtractor cell equations, with a registered borrow chain.
- Sits downstream of the combinational subtractor cells and replaces a wide ripple chain where area matters more than latency.
- Uses a start/busy/done handshake toward the controlling logic.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// Start/busy/done handshake; diff and borrow are registered and held
// until the next completion.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Partial result. The top bit of the final result is never stored here;
  // it is the cell output on the last edge and goes straight into diff.
  logic [WIDTH-2:0] res;
  logic             bin;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bout;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] res_full;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell on the current LSBs plus the registered borrow
  always_comb begin
    d        = sa[0] ^ sb[0] ^ bin;
    bout     = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
    last     = (cnt == CW'(WIDTH - 1));
    accept   = start && (state != SHIFT);
    res_full = {d, res};
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE may re-enter SHIFT directly for back-to-back use
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      bin   <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_full[WIDTH-1:1];
      bin <= bout;
      // Hold on the final bit so the counter never wraps mid-operation
      if (!last) begin
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        diff   <= res_full;
        borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with a scoreboard queue; a negedge
// monitor checks every done pulse (value and latency) and output hold.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare at every done, otherwise outputs must hold
  exp_t         e;
  logic [W-1:0] hold_d = '0;
  logic         hold_b = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_d = '0;
      hold_b = 1'b0;
    end else if (done === 1'b1) begin
      done_seen++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: diff=0x%0h with empty scoreboard", diff);
      end else begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", borrow, e.bo);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, e.ov);
`endif
        chk("latency_cycle", cyc, e.cyc);
        $display("result: diff=0x%02h borrow=%0d at cycle %0d", diff, borrow, cyc);
        hold_d = e.d;
        hold_b = e.bo;
      end
    end else begin
      chk("hold_diff", diff, hold_d);
      chk("hold_borrow", borrow, hold_b);
    end
  end

  task automatic push_exp(input logic [W-1:0] ed, input logic eb, input logic eo, input int ec);
    exp_t x;
    x.d = ed; x.bo = eb; x.ov = eo; x.cyc = ec;
    q.push_back(x);
  endtask

  // Drive one start pulse; returns at the negedge after the accepting edge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    push_exp(ed, eb, eo, cyc + 1 + W);
    $display("issue: a=0x%02h b=0x%02h expect diff=0x%02h borrow=%0d", av, bv, ed, eb);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int bc;
    int ds;
    int c0;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic operation with busy-length check
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    bc = 0;
    repeat (9) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, W);
    wait_empty();

    issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0); wait_empty();
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0); wait_empty();
    issue(8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0); wait_empty();
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1); wait_empty();
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1); wait_empty();

    // start during busy ignored; operand changes mid-SHIFT have no effect
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'h00;
    wait_empty();

    // Reset during SHIFT aborts: outputs clear, no done follows
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    ds = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", done_seen - ds, 0);

    // start held high: a result every W+1 cycles
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(8'h0F, 1'b0, 1'b0, c0 + 1 + (W + 1) * k + W);
    $display("issue: a=0x10 b=0x01 held for 4 results, expect diff=0x0f");
    repeat (4 * (W + 1)) @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
